// File: rtl/operand_stream_reader.sv
// Streams one square matrix out of the operand register over valid/ready.
// Ports: clk_i/rst_i, start_i/dim_i/col_major_i, addr_Mat_o/read_data_Mat_i,
//   out_data_o/out_valid_o/out_ready_i/out_last_o/out_end_o, busy_o/done_o.
module operand_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int MAX_DIM    = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [$clog2(MAX_DIM):0]      dim_i,
   input  logic                          col_major_i,
   output logic [ADDR_WIDTH-1:0]         addr_Mat_o,
   input  logic [DATA_WIDTH-1:0]         read_data_Mat_i,
   output logic [DATA_WIDTH-1:0]         out_data_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic                          out_last_o,
   output logic                          out_end_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int IW    = $clog2(MAX_DIM);
   localparam int DIM_W = IW + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DIM_W-1:0]      dim_clamp;
   logic [IW-1:0]         nm1;
   logic [IW-1:0]         outer;
   logic [IW-1:0]         inner;
   logic [IW-1:0]         row;
   logic [IW-1:0]         col;
   logic                  col_major;
   logic                  inner_end;
   logic                  outer_end;

   logic                  rd_pend;
   logic                  rd_last;
   logic                  rd_end;

   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic [1:0]            fifo_last;
   logic [1:0]            fifo_end;
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;

   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  last_issue;
   logic [2:0]            occ;

   assign dim_clamp = (dim_i > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : dim_i;

   assign push = rd_pend;
   assign pop  = (count != 2'd0) && out_ready_i;

   // Slots committed after this cycle: buffered + in flight - leaving now.
   assign occ   = 3'(count) + 3'(rd_pend) - 3'(pop);
   assign issue = (state == RUN) && (occ < 3'd2);

   assign inner_end  = (inner == nm1);
   assign outer_end  = (outer == nm1);
   assign last_issue = issue && inner_end && outer_end;

   assign row = col_major ? inner : outer;
   assign col = col_major ? outer : inner;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt = (dim_clamp == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy_o = 1'b1;
            if (last_issue) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy_o = 1'b1;
            // Leave once the last element is being accepted this cycle.
            if (occ == 3'd0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy_o    = 1'b1;
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         nm1       <= '0;
         col_major <= 1'b0;
         outer     <= '0;
         inner     <= '0;
         rd_pend   <= 1'b0;
         rd_last   <= 1'b0;
         rd_end    <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         fifo_last <= 2'b00;
         fifo_end  <= 2'b00;
      end else begin
         if ((state == IDLE) && start_i) begin
            nm1       <= IW'(dim_clamp - DIM_W'(1));
            col_major <= col_major_i;
            outer     <= '0;
            inner     <= '0;
         end

         // Counters stop on the final address so it stays presented.
         if (issue) begin
            rd_last <= inner_end;
            rd_end  <= inner_end && outer_end;
            if (!inner_end) begin
               inner <= inner + IW'(1);
            end else if (!outer_end) begin
               inner <= '0;
               outer <= outer + IW'(1);
            end
         end
         rd_pend <= issue;

         if (push) begin
            fifo_data[wr_ptr] <= read_data_Mat_i;
            fifo_last[wr_ptr] <= rd_last;
            fifo_end[wr_ptr]  <= rd_end;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign out_valid_o = (count != 2'd0);
   assign out_data_o  = out_valid_o ? fifo_data[rd_ptr] : '0;
   assign out_last_o  = out_valid_o && fifo_last[rd_ptr];
   assign out_end_o   = out_valid_o && fifo_end[rd_ptr];

   assign addr_Mat_o = (state == IDLE) ? '0 :
      ADDR_WIDTH'(row) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(col);

endmodule

// File: tb/tb_operand_stream_reader.sv
// Testbench for operand_stream_reader: scoreboard of the expected element
// stream built from loop order, plus literal stream and timing expectations.
module tb_operand_stream_reader;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int MD = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [2:0]    dim_i;
   logic          col_major_i;
   logic [AW-1:0] addr_Mat_o;
   logic [DW-1:0] read_data_Mat_i;
   logic [DW-1:0] out_data_o;
   logic          out_valid_o;
   logic          out_ready_i;
   logic          out_last_o;
   logic          out_end_o;
   logic          busy_o;
   logic          done_o;

   always #5 clk = ~clk;

   operand_stream_reader #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MAX_DIM(MD)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .start_i(start_i),
      .dim_i(dim_i),
      .col_major_i(col_major_i),
      .addr_Mat_o(addr_Mat_o),
      .read_data_Mat_i(read_data_Mat_i),
      .out_data_o(out_data_o),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_last_o(out_last_o),
      .out_end_o(out_end_o),
      .busy_o(busy_o),
      .done_o(done_o)
   );

   logic [DW-1:0] mem [16];
   initial begin
      for (int a = 0; a < 16; a++) mem[a] = 32'(100 + a);
   end
   always @(posedge clk) read_data_Mat_i <= mem[addr_Mat_o];

   typedef struct packed {
      logic [31:0] d;
      logic        l;
      logic        e;
   } elem_t;

   elem_t       exp_q[$];
   logic [31:0] got_d[$];
   logic        got_l[$];
   logic        got_e[$];
   int          idx_of[16];

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int accepted = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int first_valid = -1;
   int n_exp = 0;
   int ph = 0;
   bit mon_en = 0;
   bit rnd_en = 0;
   bit prev_stall = 0;
   elem_t prev_out;
   elem_t cur_m;
   elem_t e_m;
   logic [31:0] pat = 32'hB2E15C97;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d", nm, act, req);
      end
   endtask

   // Expected stream straight from the loop-order definition.
   task automatic build(input int dim, input bit cm);
      int n;
      int k;
      int a;
      elem_t e;
      n = (dim > MD) ? MD : dim;
      exp_q.delete();
      for (int i = 0; i < 16; i++) idx_of[i] = 99;
      k = 0;
      for (int o = 0; o < n; o++) begin
         for (int i = 0; i < n; i++) begin
            a = cm ? (i * MD + o) : (o * MD + i);
            e.d = mem[a];
            e.l = (i == n - 1);
            e.e = (i == n - 1) && (o == n - 1);
            exp_q.push_back(e);
            idx_of[a] = k;
            k++;
         end
      end
      n_exp = n * n;
   endtask

   initial begin
      out_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rnd_en) begin
            out_ready_i = pat[5'(ph)];
            ph++;
         end else begin
            out_ready_i = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      cur_m.d = out_data_o;
      cur_m.l = out_last_o;
      cur_m.e = out_end_o;
      if (mon_en) begin
         if (prev_stall) begin
            chk("stall_valid", 64'(out_valid_o), 64'd1);
            chk("stall_hold", 64'(cur_m), 64'(prev_out));
         end
         if (out_valid_o && first_valid < 0) first_valid = cyc;
         if (out_valid_o && out_ready_i) begin
            accepted++;
            got_d.push_back(out_data_o);
            got_l.push_back(out_last_o);
            got_e.push_back(out_end_o);
            if (exp_q.size() == 0) begin
               chk("extra_elem", 64'(accepted), 64'(n_exp));
            end else begin
               e_m = exp_q.pop_front();
               chk("elem_data", 64'(cur_m.d), 64'(e_m.d));
               chk("elem_last", 64'(cur_m.l), 64'(e_m.l));
               chk("elem_end", 64'(cur_m.e), 64'(e_m.e));
            end
         end
         if (busy_o && n_exp > 0) begin
            chk("reads_ahead_ok",
                64'(idx_of[addr_Mat_o] <= accepted + 2), 64'd1);
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev_out = cur_m;
      end else begin
         prev_stall = 0;
      end
   end

   task automatic run(input int dim, input bit cm, input bit rnd,
                      input bit pulse, input int want, output int t0);
      int k;
      build(dim, cm);
      accepted = 0;
      done_cnt = 0;
      done_cyc = -1;
      first_valid = -1;
      got_d.delete();
      got_l.delete();
      got_e.delete();
      rnd_en = rnd;
      @(posedge clk);
      #1;
      start_i = 1'b1;
      dim_i = 3'(dim);
      col_major_i = cm;
      t0 = cyc + 1;
      k = 0;
      while (done_cnt == 0 && k < 400) begin
         @(posedge clk);
         #1;
         start_i = pulse && (k == 3);
         dim_i = 3'(k + 1);
         col_major_i = ~cm;
         k++;
      end
      start_i = 1'b0;
      dim_i = '0;
      repeat (4) @(posedge clk);
      #1;
      rnd_en = 0;
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("elem_count", 64'(accepted), 64'(want));
      chk("leftover", 64'(exp_q.size()), 64'd0);
      chk("busy_after", 64'(busy_o), 64'd0);
   endtask

   int t0;
   int lit2[4] = '{100, 101, 104, 105};
   int l2[4] = '{0, 1, 0, 1};
   int e2[4] = '{0, 0, 0, 1};
   int lit3[9] = '{100, 104, 108, 101, 105, 109, 102, 106, 110};
   int l3[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

   initial begin
      rst_i = 1'b1;
      start_i = 1'b0;
      dim_i = '0;
      col_major_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {out_valid_o, out_last_o, out_end_o, busy_o,
          done_o, out_data_o, addr_Mat_o}, 64'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      mon_en = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_outs", {out_valid_o, out_last_o, out_end_o, busy_o,
             done_o, out_data_o, addr_Mat_o}, 64'd0);
      end

      run(2, 0, 0, 0, 4, t0);
      chk("n2_first_valid", 64'(first_valid - t0), 64'd3);
      chk("n2_done_cycle", 64'(done_cyc - t0), 64'd7);
      chk("n2_len", 64'(got_d.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_d.size()) begin
            chk("n2_data", 64'(got_d[i]), 64'(lit2[i]));
            chk("n2_last", 64'(got_l[i]), 64'(l2[i]));
            chk("n2_end", 64'(got_e[i]), 64'(e2[i]));
         end
      end

      run(3, 1, 0, 1, 9, t0);
      chk("n3_done_cycle", 64'(done_cyc - t0), 64'd12);
      chk("n3_len", 64'(got_d.size()), 64'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < got_d.size()) begin
            chk("n3_data", 64'(got_d[i]), 64'(lit3[i]));
            chk("n3_last", 64'(got_l[i]), 64'(l3[i]));
         end
      end

      run(4, 0, 1, 0, 16, t0);

      run(0, 0, 0, 0, 0, t0);
      chk("n0_done_cycle", 64'(done_cyc - t0), 64'd1);
      chk("n0_no_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);

      run(7, 1, 0, 0, 16, t0);

      build(4, 0);
      accepted = 0;
      done_cnt = 0;
      @(posedge clk);
      #1;
      start_i = 1'b1;
      dim_i = 3'd4;
      col_major_i = 1'b0;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      for (int k = 0; k < 100 && accepted < 5; k++) @(posedge clk);
      #1;
      mon_en = 0;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      exp_q.delete();
      n_exp = 0;
      done_cnt = 0;
      mon_en = 1;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_no_done", 64'(done_cnt), 64'd0);

      run(4, 1, 1, 0, 16, t0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
